// File: rtl/mips_dcache.sv
// Direct-mapped, write-back, write-allocate data cache with one-word lines.
// Stalls the core on misses and writes back every dirty line on a flush request.
module mips_dcache #(
    parameter int XLEN        = 32,
    parameter int LINES       = 16,
    parameter int MEM_LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic [XLEN-1:0]   cpu_addr,
    input  logic              cpu_rd_en,
    input  logic              cpu_wr_en,
    input  logic [XLEN/8-1:0] cpu_byte_en,
    input  logic [7:0]        cpu_wdata    [XLEN/8],
    output logic [7:0]        cpu_rdata    [XLEN/8],
    output logic              cpu_stall,
    input  logic              flush_req,
    output logic              flush_done,
    output logic [XLEN-1:0]   mem_addr,
    output logic [7:0]        mem_data_out [XLEN/8],
    input  logic [7:0]        mem_data_in  [XLEN/8],
    output logic              mem_write_en,
    output logic [1:0]        dbg_state
);
    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);
    localparam int IW = $clog2(LINES);
    localparam int TW = XLEN - OW - IW;
    localparam int CW = $clog2(MEM_LATENCY + 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITEBACK = 2'd1,
        S_FILL      = 2'd2,
        S_FLUSH     = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [LINES-1:0]   r_valid;
    logic [LINES-1:0]   r_dirty;
    logic [TW-1:0]      r_tag [LINES];
    logic [NB-1:0][7:0] r_data [LINES];
    logic [CW-1:0]      r_cnt;
    logic [IW-1:0]      r_flush_idx;
    logic               r_flush_done;
    logic               r_flush_req_d;
    logic [XLEN-1:OW]   r_req_word;
    logic [XLEN-1:0]    r_mem_addr;
    logic [NB-1:0][7:0] r_mem_data;

    logic               w_req;
    logic [IW-1:0]      w_idx;
    logic [TW-1:0]      w_tag;
    logic               w_hit;
    logic               w_victim_dirty;
    logic               w_cnt_run;
    logic               w_cnt_last;
    logic [IW-1:0]      w_fill_idx;
    logic [TW-1:0]      w_fill_tag;
    logic               w_flush_dirty;
    logic               w_flush_step;
    logic               w_flush_last;
    logic [IW-1:0]      w_flush_next;
    logic               w_flush_rise;
    logic               w_flush_start;
    logic               w_unused_offset;

    assign w_req          = cpu_rd_en | cpu_wr_en;
    assign w_idx          = cpu_addr[OW +: IW];
    assign w_tag          = cpu_addr[XLEN-1 -: TW];
    assign w_hit          = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_victim_dirty = r_valid[w_idx] && r_dirty[w_idx];
    assign w_unused_offset = ^cpu_addr[OW-1:0];

    // The fill target is latched at the miss so a wandering request cannot corrupt it.
    assign w_fill_idx = r_req_word[OW +: IW];
    assign w_fill_tag = r_req_word[XLEN-1 -: TW];

    assign w_flush_dirty = r_valid[r_flush_idx] && r_dirty[r_flush_idx];
    assign w_flush_last  = (r_flush_idx == IW'(LINES - 1));
    assign w_flush_next  = r_flush_idx + 1'b1;
    assign w_flush_rise  = flush_req && !r_flush_req_d;
    assign w_flush_start = flush_req && !w_req && (!r_flush_done || w_flush_rise);

    assign w_cnt_run    = (r_state == S_WRITEBACK) || (r_state == S_FILL) ||
                          ((r_state == S_FLUSH) && w_flush_dirty);
    assign w_cnt_last   = (r_cnt == CW'(MEM_LATENCY - 1));
    assign w_flush_step = !w_flush_dirty || w_cnt_last;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req && !w_hit) begin
                    w_next_state = w_victim_dirty ? S_WRITEBACK : S_FILL;
                end else if (w_flush_start) begin
                    w_next_state = S_FLUSH;
                end
            end
            S_WRITEBACK: if (w_cnt_last) w_next_state = S_FILL;
            S_FILL:      if (w_cnt_last) w_next_state = S_IDLE;
            S_FLUSH:     if (w_flush_step && w_flush_last) w_next_state = S_IDLE;
            default:     w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        cpu_stall    = 1'b1;
        mem_write_en = 1'b0;
        case (r_state)
            S_IDLE:      cpu_stall    = w_req && !w_hit;
            S_WRITEBACK: mem_write_en = 1'b1;
            S_FLUSH:     mem_write_en = w_flush_dirty;
            default:     ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_valid       <= '0;
            r_dirty       <= '0;
            r_cnt         <= '0;
            r_flush_idx   <= '0;
            r_flush_done  <= 1'b0;
            r_flush_req_d <= 1'b0;
            r_req_word    <= '0;
            r_mem_addr    <= '0;
        end else begin
            r_flush_req_d <= flush_req;
            if (w_cnt_run && !w_cnt_last) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_req || w_flush_rise) r_flush_done <= 1'b0;
                    if (w_req && w_hit && cpu_wr_en) r_dirty[w_idx] <= 1'b1;
                    if (w_req && !w_hit) begin
                        r_req_word <= cpu_addr[XLEN-1:OW];
                        r_mem_addr <= w_victim_dirty ? {r_tag[w_idx], w_idx, {OW{1'b0}}}
                                                     : {cpu_addr[XLEN-1:OW], {OW{1'b0}}};
                    end else if (w_flush_start) begin
                        r_flush_idx <= '0;
                        r_mem_addr  <= {r_tag[0], {IW{1'b0}}, {OW{1'b0}}};
                    end
                end
                S_WRITEBACK: begin
                    if (w_cnt_last) r_mem_addr <= {r_req_word, {OW{1'b0}}};
                end
                S_FILL: begin
                    if (w_cnt_last) begin
                        r_valid[w_fill_idx] <= 1'b1;
                        r_dirty[w_fill_idx] <= 1'b0;
                    end
                end
                S_FLUSH: begin
                    if (w_flush_dirty && w_cnt_last) r_dirty[r_flush_idx] <= 1'b0;
                    if (w_flush_step) begin
                        if (w_flush_last) begin
                            r_flush_done <= 1'b1;
                        end else begin
                            r_flush_idx <= w_flush_next;
                            r_mem_addr  <= {r_tag[w_flush_next], w_flush_next, {OW{1'b0}}};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Line storage and the writeback data register carry no reset.
    always_ff @(posedge clk) begin
        if ((r_state == S_IDLE) && w_req && w_hit && cpu_wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (cpu_byte_en[b]) r_data[w_idx][b] <= cpu_wdata[b];
            end
        end
        if ((r_state == S_FILL) && w_cnt_last) begin
            r_tag[w_fill_idx] <= w_fill_tag;
            for (int b = 0; b < NB; b++) begin
                r_data[w_fill_idx][b] <= mem_data_in[b];
            end
        end
        if (r_state == S_IDLE) begin
            if (w_req && !w_hit) begin
                r_mem_data <= r_data[w_idx];
            end else if (w_flush_start) begin
                r_mem_data <= r_data[0];
            end
        end
        if ((r_state == S_FLUSH) && w_flush_step && !w_flush_last) begin
            r_mem_data <= r_data[w_flush_next];
        end
    end

    always_comb begin
        for (int b = 0; b < NB; b++) begin
            cpu_rdata[b]    = r_data[w_idx][b];
            mem_data_out[b] = r_mem_data[b];
        end
    end

    assign mem_addr   = r_mem_addr;
    assign flush_done = r_flush_done;
    assign dbg_state  = r_state;

endmodule

// File: doc/mips_dcache.md
# mips_dcache

Parametrised direct-mapped, write-back, write-allocate data cache between the MIPS core's load/store port and the byte-lane data memory. It replaces the core's direct zero-latency memory connection with one that tolerates a fixed multi-cycle memory latency. It stalls the core on misses and supports a whole-cache flush so all dirty data reaches memory before `halted` is honoured.

## Interface
Parameters:
- `XLEN`, 32: address/data width; must be a multiple of 8. `NB = XLEN/8` byte lanes.
- `LINES`, 16: number of one-word lines; power of two, ≥2. `IW = log2(LINES)`.
- `MEM_LATENCY`, 4: cycles a memory read or write must be held; ≥1.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_b`  in  1  reset, asynchronous, active-low.
- `cpu_addr`  in  XLEN  byte address; the low `log2(NB)` bits are ignored.
- `cpu_rd_en`  in  1  load request.
- `cpu_wr_en`  in  1  store request; wins if asserted together with `cpu_rd_en`.
- `cpu_byte_en`  in  NB  store byte-lane enables.
- `cpu_wdata`  in  8×NB array [0:NB-1]  store data, lane 0 = lowest address.
- `cpu_rdata`  out  8×NB array  load data.
- `cpu_stall`  out  1  core must hold its request and freeze the PC.
- `flush_req`  in  1  write back all dirty lines.
- `flush_done`  out  1  flush complete.
- `mem_addr`  out  XLEN  word-aligned memory address.
- `mem_data_out`  out  8×NB array  write data to memory.
- `mem_data_in`  in  8×NB array  read data from memory.
- `mem_write_en`  out  1  memory write strobe.

## Operation
- Address split: offset `[log2(NB)-1:0]`; index `[log2(NB)+IW-1:log2(NB)]`; the remaining upper bits are the tag.
- Per line: valid bit, dirty bit, tag, and NB data bytes. Only the valid and dirty bits are reset.
- FSM states: IDLE, WRITEBACK, FILL, FLUSH.
- **IDLE**
  - A request hits when the line is valid and its tag matches.
  - Read hit: `cpu_rdata` shows the line data combinationally; `cpu_stall`=0.
  - Write hit: the enabled bytes are written at the edge and dirty is set; `cpu_stall`=0.
  - Miss: `cpu_stall`=1 combinationally. Next state is WRITEBACK if the victim line is valid and dirty, otherwise FILL.
- **WRITEBACK**
  - Holds for MEM_LATENCY cycles with `mem_write_en`=1.
  - `mem_addr` = {victim tag, index, zeros}; `mem_data_out` = victim data.
  - Then goes to FILL.
- **FILL**
  - Holds for MEM_LATENCY cycles with `mem_write_en`=0 and `mem_addr` = the requested word address.
  - On the last cycle, captures `mem_data_in`, sets valid=1, dirty=0, and the new tag, then returns to IDLE.
  - The held request then hits: a load returns data; a store merges and sets dirty.
- **FLUSH**
  - Entered from IDLE when `flush_req`=1 and no access is asserted. An access asserted in the same cycle is served first.
  - Walks the index from 0 to LINES-1. A dirty line costs MEM_LATENCY write cycles, then its dirty bit is cleared. A clean or invalid line costs 1 cycle.
  - After the last index, returns to IDLE and sets `flush_done`=1.
  - `flush_done` stays high until the next `flush_req` rising or any access. The cache stays valid after a flush.
- `cpu_stall`=1 in every non-IDLE state.
- `mem_write_en`=1 only in WRITEBACK and in FLUSH on dirty lines.
- A request that drops while stalled is illegal. The FSM still completes the fill.

## Timing
- Reset values: `cpu_stall`=0, `mem_write_en`=0, `mem_addr`=0, `flush_done`=0, state=IDLE, all valid and dirty bits=0. `cpu_rdata` and `mem_data_out` are don't-care.
- Reset asserted mid-operation aborts immediately. A partial writeback is lost, and the line being filled stays invalid.
- Hit latency: 0 stall cycles.
- Clean miss: MEM_LATENCY+1 stall cycles.
- Dirty miss: 2·MEM_LATENCY+1 stall cycles.
- Flush duration: LINES + D·(MEM_LATENCY−1) cycles, where D = number of dirty lines.
- `mem_addr` and `mem_data_out` are registered from state. They are stable for the whole MEM_LATENCY window.
- Index wrap: the flush counter stops at LINES-1 and does not wrap.

## Test plan
- **Cold read:** after reset, read 0x40 with mem[0x40]=0xDEADBEEF and MEM_LATENCY=4. Expect stall for 5 cycles, then rdata=0xDEADBEEF with no further stall; a re-read hits with 0 stalls.
- **Write-hit byte merge:** line 0x40 cached. Write byte_en=0b0010, lane1=0xAA. Expect a read to return 0xDEADAAEF (lane1 replaced) and `mem_write_en` to stay 0.
- **Dirty eviction:** with line 0x40 dirty and LINES=16, read 0x80 (same index). Expect 4 cycles of `mem_write_en`=1 with addr 0x40 and the dirty data, then 4 fill cycles at addr 0x80: 9 stall cycles total.
- **Write miss:** store 0x11 to lane 0 at 0xC4 on a clean line. Expect a fill from mem[0xC4], then the merged word, with dirty set.
- **Flush:** lines 1 and 5 dirty. Assert `flush_req`. Expect exactly two 4-cycle write bursts to those addresses, 16+2·3=22 cycles total, then `flush_done`=1.
- **Reset mid-FILL:** pulse `rst_b` low during cycle 2 of a fill. Expect stall=0, `mem_write_en`=0, and the next access to the same address misses.
